// File: rtl/ascon_pkg.sv
// Shared definitions for the Ascon permutation sequencer: round limits,
// FSM state encoding and the round-constant helper.
package ascon_pkg;

    localparam int ASCON_ROUNDS_MAX = 12;
    localparam logic [3:0] RC_IDX_LAST = 4'(ASCON_ROUNDS_MAX - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_LOAD  = ST_LOAD,
        S_ROUND = ST_ROUND,
        S_DONE  = ST_DONE
    } perm_state_t;

    // Round constant for round index i: high nibble is the complement of i.
    function automatic logic [7:0] ascon_rc(input logic [3:0] i);
        return {~i, i};
    endfunction

endpackage

// File: rtl/ascon_round_ctr.sv
// Loadable 4-bit round index counter; saturates at the final round index
// so it never passes 11.
module ascon_round_ctr
    import ascon_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_inc,
    output logic [3:0] o_cnt,
    output logic       o_last
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_inc && (r_cnt != RC_IDX_LAST)) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == RC_IDX_LAST);

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Ascon permutation sequencer: accepts p^a / p^b requests, drives state load,
// per-round enables with index and constant, and hands completion back.
module ascon_perm_ctrl
    import ascon_pkg::*;
#(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_valid,
    output logic       start_ready,
    input  logic       mode_b,
    input  logic       hold,
    input  logic       abort,
    output logic       perm_load,
    output logic       round_en,
    output logic       last_round,
    output logic [3:0] rc_idx,
    output logic [7:0] rc,
    output logic       busy,
    output logic       done_valid,
    input  logic       done_ready
);

    generate
        if ((ROUNDS_A < 1) || (ROUNDS_A > ASCON_ROUNDS_MAX) ||
            (ROUNDS_B < 1) || (ROUNDS_B > ASCON_ROUNDS_MAX)) begin : g_bad_rounds
            $error("ascon_perm_ctrl: ROUNDS_A/ROUNDS_B must be in 1..12");
        end
    endgenerate

    // Rounds always finish on index 11, so a shorter permutation starts later.
    localparam logic [3:0] START_IDX_A = 4'(ASCON_ROUNDS_MAX - ROUNDS_A);
    localparam logic [3:0] START_IDX_B = 4'(ASCON_ROUNDS_MAX - ROUNDS_B);

    perm_state_t r_state;
    perm_state_t w_state_nxt;
    logic        r_mode_b;

    logic        w_accept;
    logic        w_round_en;
    logic        w_ctr_load;
    logic [3:0]  w_ctr_load_val;
    logic [3:0]  w_cnt;
    logic        w_cnt_last;

    assign w_accept   = (r_state == S_IDLE) && start_valid && !abort;
    assign w_round_en = (r_state == S_ROUND) && !hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode_b <= 1'b0;
        end else if (w_accept) begin
            r_mode_b <= mode_b;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_valid) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_ROUND;
            S_ROUND: if (w_round_en && w_cnt_last) w_state_nxt = S_DONE;
            S_DONE:  if (done_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Counter is cleared whenever the sequencer returns to idle so the
    // index output rests at 0 between requests.
    always_comb begin
        w_ctr_load     = 1'b0;
        w_ctr_load_val = 4'd0;
        if (abort || ((r_state == S_DONE) && done_ready)) begin
            w_ctr_load = 1'b1;
        end else if (r_state == S_LOAD) begin
            w_ctr_load     = 1'b1;
            w_ctr_load_val = r_mode_b ? START_IDX_B : START_IDX_A;
        end
    end

    ascon_round_ctr u_round_ctr (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_ctr_load),
        .i_load_val (w_ctr_load_val),
        .i_inc      (w_round_en),
        .o_cnt      (w_cnt),
        .o_last     (w_cnt_last)
    );

    assign start_ready = (r_state == S_IDLE);
    assign perm_load   = (r_state == S_LOAD);
    assign round_en    = w_round_en;
    assign last_round  = w_round_en && w_cnt_last;
    assign rc_idx      = w_cnt;
    assign rc          = ascon_rc(w_cnt);
    assign busy        = (r_state != S_IDLE);
    assign done_valid  = (r_state == S_DONE);

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Self-checking bench for ascon_perm_ctrl: per-scenario tasks plus a
// round/completion scoreboard filled at request accept.
module tb_ascon_perm_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_valid, mode_b, hold, abort, done_ready;
    logic       start_ready, perm_load, round_en, last_round, busy, done_valid;
    logic [3:0] rc_idx;
    logic [7:0] rc;
    logic       start_ready_8, perm_load_8, round_en_8, last_round_8, busy_8, done_valid_8;
    logic [3:0] rc_idx_8;
    logic [7:0] rc_8;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    int exp_q[$];
    int done_q[$];
    logic [7:0] rc_tab [12] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
                                8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

    int acc_cyc = -1, load_cyc = -1, first_re_cyc = -1, last_re_cyc = -1, done_cyc = -1;
    int re_cnt = 0;
    int first8_cyc = -1, done8_cyc = -1;
    logic [7:0] rc8_first = 8'h00;
    logic prev_done = 1'b0, prev_re8 = 1'b0, prev_done8 = 1'b0;

    ascon_perm_ctrl #(.ROUNDS_A(12), .ROUNDS_B(6)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .mode_b(mode_b), .hold(hold), .abort(abort), .perm_load(perm_load),
        .round_en(round_en), .last_round(last_round), .rc_idx(rc_idx), .rc(rc),
        .busy(busy), .done_valid(done_valid), .done_ready(done_ready)
    );

    ascon_perm_ctrl #(.ROUNDS_A(12), .ROUNDS_B(8)) dut8 (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready_8),
        .mode_b(mode_b), .hold(hold), .abort(abort), .perm_load(perm_load_8),
        .round_en(round_en_8), .last_round(last_round_8), .rc_idx(rc_idx_8), .rc(rc_8),
        .busy(busy_8), .done_valid(done_valid_8), .done_ready(done_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock cycle: sample at negedge, run the scoreboard, then step past posedge.
    task automatic cyc();
        int e;
        int n;
        @(negedge clk);
        if (start_valid && start_ready && !abort) begin
            n = mode_b ? 6 : 12;
            for (int k = 12 - n; k < 12; k++) exp_q.push_back(k);
            done_q.push_back(n);
            acc_cyc = cyc_n; load_cyc = -1; first_re_cyc = -1; last_re_cyc = -1;
            done_cyc = -1; re_cnt = 0; first8_cyc = -1; done8_cyc = -1;
        end
        if (perm_load) load_cyc = cyc_n;
        if (round_en) begin
            re_cnt++;
            if (first_re_cyc < 0) first_re_cyc = cyc_n;
            last_re_cyc = cyc_n;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_round_en: cycle=%0d rc_idx=%0d, no round expected", cyc_n, rc_idx);
            end else begin
                e = exp_q.pop_front();
                total++;
                if (rc_idx !== e[3:0] || rc !== rc_tab[e] || last_round !== (e == 11)) begin
                    bad++;
                    $display("FAIL round_seq: got idx=%0d rc=%h last=%b, want idx=%0d rc=%h last=%b",
                             rc_idx, rc, last_round, e, rc_tab[e], (e == 11));
                end
            end
        end else if (last_round !== 1'b0) begin
            total++; bad++;
            $display("FAIL last_round_without_en: got %b, want 0", last_round);
        end
        if (done_valid && !prev_done) done_cyc = cyc_n;
        if (done_valid && done_ready) begin
            total++;
            if (done_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: cycle=%0d, no completion expected", cyc_n);
            end else begin
                n = done_q.pop_front();
                if (re_cnt !== n || exp_q.size() != 0) begin
                    bad++;
                    $display("FAIL round_count: got %0d rounds (%0d pending), want %0d", re_cnt, exp_q.size(), n);
                end
            end
        end
        prev_done = done_valid;
        if (round_en_8 && !prev_re8 && first8_cyc < 0) begin
            first8_cyc = cyc_n;
            rc8_first  = rc_8;
        end
        if (done_valid_8 && !prev_done8) done8_cyc = cyc_n;
        prev_re8   = round_en_8;
        prev_done8 = done_valid_8;
        @(posedge clk);
        cyc_n++;
        #1;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        while (done_cyc < 0 && k < budget) begin
            cyc();
            k++;
        end
        total++;
        if (done_cyc < 0) begin
            bad++;
            $display("FAIL %s_timeout: no done_valid within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total += 8;
        if (perm_load !== 1'b0)   begin bad++; $display("FAIL rst_perm_load: got %b want 0", perm_load); end
        if (round_en !== 1'b0)    begin bad++; $display("FAIL rst_round_en: got %b want 0", round_en); end
        if (last_round !== 1'b0)  begin bad++; $display("FAIL rst_last_round: got %b want 0", last_round); end
        if (done_valid !== 1'b0)  begin bad++; $display("FAIL rst_done_valid: got %b want 0", done_valid); end
        if (busy !== 1'b0)        begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (start_ready !== 1'b1) begin bad++; $display("FAIL rst_start_ready: got %b want 1", start_ready); end
        if (rc_idx !== 4'd0)      begin bad++; $display("FAIL rst_rc_idx: got %0d want 0", rc_idx); end
        if (rc !== 8'hf0)         begin bad++; $display("FAIL rst_rc: got %h want f0", rc); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_pa();
        start_valid = 1'b1; mode_b = 1'b0;
        cyc();
        start_valid = 1'b0; mode_b = 1'b1;
        wait_done(40, "pa");
        cyc();
        total += 4;
        if (load_cyc !== acc_cyc + 1)      begin bad++; $display("FAIL pa_load: got cycle %0d want %0d", load_cyc, acc_cyc + 1); end
        if (first_re_cyc !== acc_cyc + 2)  begin bad++; $display("FAIL pa_first_round: got cycle %0d want %0d", first_re_cyc, acc_cyc + 2); end
        if (last_re_cyc !== acc_cyc + 13)  begin bad++; $display("FAIL pa_last_round: got cycle %0d want %0d", last_re_cyc, acc_cyc + 13); end
        if (done_cyc !== acc_cyc + 14)     begin bad++; $display("FAIL pa_done: got cycle %0d want %0d", done_cyc, acc_cyc + 14); end
    endtask

    task automatic test_pb();
        int k = 0;
        start_valid = 1'b1; mode_b = 1'b1;
        cyc();
        start_valid = 1'b0; mode_b = 1'b0;
        while (done8_cyc < 0 && k < 30) begin
            cyc();
            k++;
        end
        cyc();
        total += 6;
        if (load_cyc !== acc_cyc + 1)     begin bad++; $display("FAIL pb_load: got cycle %0d want %0d", load_cyc, acc_cyc + 1); end
        if (first_re_cyc !== acc_cyc + 2) begin bad++; $display("FAIL pb_first_round: got cycle %0d want %0d", first_re_cyc, acc_cyc + 2); end
        if (done_cyc !== acc_cyc + 8)     begin bad++; $display("FAIL pb_done: got cycle %0d want %0d", done_cyc, acc_cyc + 8); end
        if (first8_cyc !== acc_cyc + 2)   begin bad++; $display("FAIL pb8_first_round: got cycle %0d want %0d", first8_cyc, acc_cyc + 2); end
        if (rc8_first !== 8'hb4)          begin bad++; $display("FAIL pb8_first_rc: got %h want b4", rc8_first); end
        if (done8_cyc !== acc_cyc + 10)   begin bad++; $display("FAIL pb8_done: got cycle %0d want %0d", done8_cyc, acc_cyc + 10); end
    endtask

    task automatic test_hold();
        int holds = 0;
        int k = 0;
        start_valid = 1'b1; mode_b = 1'b0;
        cyc();
        start_valid = 1'b0;
        while (done_cyc < 0 && k < 40) begin
            hold = busy && !perm_load && !done_valid && (rc_idx == 4'd3) && (holds < 2);
            if (hold) begin
                holds++;
                #1;
                total += 2;
                if (round_en !== 1'b0) begin bad++; $display("FAIL hold_round_en: got %b want 0", round_en); end
                if (rc_idx !== 4'd3)   begin bad++; $display("FAIL hold_rc_idx: got %0d want 3", rc_idx); end
            end
            cyc();
            k++;
        end
        hold = 1'b0;
        cyc();
        total += 2;
        if (holds !== 2)               begin bad++; $display("FAIL hold_applied: got %0d hold cycles want 2", holds); end
        if (done_cyc !== acc_cyc + 16) begin bad++; $display("FAIL hold_done: got cycle %0d want %0d", done_cyc, acc_cyc + 16); end
    endtask

    task automatic test_done_stall();
        int hs;
        done_ready = 1'b0;
        start_valid = 1'b1; mode_b = 1'b1;
        cyc();
        start_valid = 1'b0;
        wait_done(30, "stall");
        for (int i = 0; i < 5; i++) begin
            start_valid = 1'b1; mode_b = 1'b0;
            #1;
            total += 2;
            if (start_ready !== 1'b0) begin bad++; $display("FAIL stall_start_ready: got %b want 0", start_ready); end
            if (done_valid !== 1'b1)  begin bad++; $display("FAIL stall_done_valid: got %b want 1", done_valid); end
            cyc();
        end
        done_ready = 1'b1;
        hs = cyc_n;
        cyc();
        total += 2;
        if (start_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready: got %b want 1", start_ready); end
        cyc();
        if (acc_cyc !== hs + 1)   begin bad++; $display("FAIL stall_next_accept: got cycle %0d want %0d", acc_cyc, hs + 1); end
        start_valid = 1'b0;
        wait_done(40, "stall_next");
        cyc();
        total++;
        if (done_cyc !== acc_cyc + 14) begin bad++; $display("FAIL stall_next_done: got cycle %0d want %0d", done_cyc, acc_cyc + 14); end
    endtask

    task automatic test_abort();
        int k = 0;
        int dv_seen = 0;
        start_valid = 1'b1; mode_b = 1'b0;
        cyc();
        start_valid = 1'b0;
        while (!(busy && !perm_load && !done_valid && rc_idx == 4'd5) && k < 20) begin
            cyc();
            k++;
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        exp_q.delete();
        done_q.delete();
        total += 3;
        if (busy !== 1'b0)        begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        if (start_ready !== 1'b1) begin bad++; $display("FAIL abort_start_ready: got %b want 1", start_ready); end
        if (round_en !== 1'b0)    begin bad++; $display("FAIL abort_round_en: got %b want 0", round_en); end
        for (int i = 0; i < 15; i++) begin
            cyc();
            if (done_valid) dv_seen++;
        end
        total++;
        if (dv_seen !== 0) begin bad++; $display("FAIL abort_done_valid: got %0d cycles want 0", dv_seen); end
        abort = 1'b1; start_valid = 1'b1;
        cyc();
        abort = 1'b0; start_valid = 1'b0;
        total += 2;
        if (busy !== 1'b0)      begin bad++; $display("FAIL abort_idle_busy: got %b want 0", busy); end
        if (perm_load !== 1'b0) begin bad++; $display("FAIL abort_idle_load: got %b want 0", perm_load); end
        cyc();
    endtask

    task automatic test_async_rst();
        start_valid = 1'b1; mode_b = 1'b0;
        cyc();
        start_valid = 1'b0;
        repeat (5) cyc();
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        done_q.delete();
        total += 6;
        if (busy !== 1'b0)        begin bad++; $display("FAIL arst_busy: got %b want 0", busy); end
        if (round_en !== 1'b0)    begin bad++; $display("FAIL arst_round_en: got %b want 0", round_en); end
        if (start_ready !== 1'b1) begin bad++; $display("FAIL arst_start_ready: got %b want 1", start_ready); end
        if (rc_idx !== 4'd0)      begin bad++; $display("FAIL arst_rc_idx: got %0d want 0", rc_idx); end
        if (rc !== 8'hf0)         begin bad++; $display("FAIL arst_rc: got %h want f0", rc); end
        if (done_valid !== 1'b0)  begin bad++; $display("FAIL arst_done_valid: got %b want 0", done_valid); end
        cyc();
        rst = 1'b0;
        #1;
        total++;
        if (start_ready !== 1'b1) begin bad++; $display("FAIL arst_release_ready: got %b want 1", start_ready); end
        start_valid = 1'b1; mode_b = 1'b0;
        cyc();
        start_valid = 1'b0;
        wait_done(40, "arst_fresh");
        cyc();
        total++;
        if (done_cyc !== acc_cyc + 14) begin bad++; $display("FAIL arst_fresh_done: got cycle %0d want %0d", done_cyc, acc_cyc + 14); end
    endtask

    initial begin
        rst = 1'b1; start_valid = 1'b0; mode_b = 1'b0; hold = 1'b0;
        abort = 1'b0; done_ready = 1'b1;
        test_reset();
        cyc();
        test_pa();
        test_pb();
        test_hold();
        test_done_stall();
        test_abort();
        test_async_rst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
